// File: rtl/sif_resp_mem.sv
// sif_resp_mem: SIF bus responder with byte-enable word memory, single-cycle ack and out-of-range err.
// Optional wait states before ack when SIF_RESP_WAIT_EN is defined.
module sif_resp_mem #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wd,
    input  logic [DW/8-1:0] be,
    input  logic [3:0]      wait_cfg,
    output logic            ack,
    output logic [DW-1:0]   rd,
    output logic            err,
    output logic            busy
);
    localparam int NB = DW / 8;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t          state;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   c_addr;
    logic            c_we;
    logic [DW-1:0]   c_wd;
    logic [NB-1:0]   c_be;
    logic            commit;
    logic            in_range;
    logic [IW-1:0]   idx;
`ifdef SIF_RESP_WAIT_EN
    logic [3:0]      cnt;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [DW-1:0]   wd_q;
    logic [NB-1:0]   be_q;
    // A zero-wait request commits on its acceptance edge, before the latches are loaded.
    assign c_addr = state == IDLE ? addr : addr_q;
    assign c_we   = state == IDLE ? we : we_q;
    assign c_wd   = state == IDLE ? wd : wd_q;
    assign c_be   = state == IDLE ? be : be_q;
    assign commit = !rst && (state == IDLE ? req && wait_cfg == 4'd0 : state == WAIT && cnt == 4'd1);
`else
    logic            unused_wait;
    assign unused_wait = ^wait_cfg;
    assign c_addr = addr;
    assign c_we   = we;
    assign c_wd   = wd;
    assign c_be   = be;
    assign commit = !rst && state == IDLE && req;
`endif
    assign in_range = {1'b0, c_addr} < (AW+1)'(DEPTH);
    assign idx      = c_addr[IW-1:0];
    always_ff @(posedge clk)
        if (commit && c_we && in_range)
            for (int i = 0; i < NB; i++)
                if (c_be[i]) mem[idx][8*i +: 8] <= c_wd[8*i +: 8];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ack   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            rd    <= '0;
`ifdef SIF_RESP_WAIT_EN
            cnt   <= 4'd0;
`endif
        end else begin
            ack <= commit;
            err <= commit && !in_range;
            if (commit && !c_we) rd <= in_range ? mem[idx] : '0;
            case (state)
                IDLE: if (req) begin
                    busy <= 1'b1;
`ifdef SIF_RESP_WAIT_EN
                    addr_q <= addr;
                    we_q   <= we;
                    wd_q   <= wd;
                    be_q   <= be;
                    cnt    <= wait_cfg;
                    state  <= wait_cfg == 4'd0 ? RESP : WAIT;
`else
                    state <= RESP;
`endif
                end
`ifdef SIF_RESP_WAIT_EN
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= cnt == 4'd1 ? RESP : WAIT;
                end
`endif
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sif_resp_mem.sv
// tb_sif_resp_mem: table-driven and randomized checks of sif_resp_mem against a word-array model.
module tb_sif_resp_mem;
`ifdef SIF_RESP_WAIT_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif
    logic        clk, rst, req, we, ack, err, busy;
    logic [7:0]  addr;
    logic [31:0] wd, rd;
    logic [3:0]  be, wait_cfg;
    int checks = 0, errors = 0;
    logic [31:0] mm [64];
    logic [31:0] last_rd;

    sif_resp_mem dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd), .be(be),
        .wait_cfg(wait_cfg), .ack(ack), .rd(rd), .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t vt [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void mwrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        if (a < 8'd64)
            for (int i = 0; i < 4; i++)
                if (b[i]) mm[a[5:0]][8*i +: 8] = d[8*i +: 8];
    endfunction

    // Drives one transaction from an idle bus; caller is positioned 1 time unit after a rising edge.
    task automatic txn(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b,
                       input logic [3:0] wc, output int lat, output logic e, output logic [31:0] r);
        we = w; addr = a; wd = d; be = b; wait_cfg = wc; req = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!ack) begin
                addr = 8'($urandom); wd = $urandom; be = 4'($urandom);
                we = 1'($urandom); wait_cfg = 4'($urandom);
            end
        end while (!ack && lat < 40);
        e = err; r = rd;
        check("busy_in_ack", 32'(busy), 32'd1);
        req = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("busy_after_ack", 32'(busy), 32'd0);
    endtask

    task automatic model_txn(input string tag, input bit w, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] b, input logic [3:0] wc);
        int lat; logic e; logic [31:0] r, exp_rd;
        exp_rd = w ? last_rd : (a < 8'd64 ? mm[a[5:0]] : 32'd0);
        txn(w, a, d, b, wc, lat, e, r);
        check({tag, "_lat"}, 32'(lat), 32'(1 + (WEN ? int'(wc) : 0)));
        check({tag, "_err"}, 32'(e), 32'(a >= 8'd64));
        check({tag, "_rd"}, r, exp_rd);
        last_rd = exp_rd;
        if (w) mwrite(a, d, b);
    endtask

    initial begin
        int lat, t; logic e; logic [31:0] r;
        bit w; logic [7:0] a; logic [3:0] b, wc;
        req = 0; we = 0; addr = 0; wd = 0; be = 0; wait_cfg = 0; rst = 1'b1;
        last_rd = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_ack", 32'(ack), 32'd0);
            check("idle_err", 32'(err), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_rd", rd, 32'd0);
        end
        for (int i = 0; i < 64; i++) model_txn("init", 1'b1, 8'(i), $urandom, 4'hF, 4'd0);

        vt[0]  = '{1'b1, 8'd3,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 8'd3,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 8'd3,   32'h00000011, 4'h1, 1'b0, 32'h0,        1'b0};
        vt[3]  = '{1'b0, 8'd3,   32'h0,        4'h0, 1'b1, 32'hDEADBE11, 1'b0};
        vt[4]  = '{1'b0, 8'd64,  32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        vt[5]  = '{1'b0, 8'd3,   32'h0,        4'h0, 1'b1, 32'hDEADBE11, 1'b0};
        vt[6]  = '{1'b1, 8'd200, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1'b1};
        vt[7]  = '{1'b0, 8'd3,   32'h0,        4'h0, 1'b1, 32'hDEADBE11, 1'b0};
        vt[8]  = '{1'b1, 8'd3,   32'hAABBCCDD, 4'h0, 1'b0, 32'h0,        1'b0};
        vt[9]  = '{1'b0, 8'd3,   32'h0,        4'h0, 1'b1, 32'hDEADBE11, 1'b0};
        vt[10] = '{1'b1, 8'd3,   32'h12345678, 4'hA, 1'b0, 32'h0,        1'b0};
        vt[11] = '{1'b0, 8'd3,   32'h0,        4'h0, 1'b1, 32'h12AD5611, 1'b0};
        vt[12] = '{1'b1, 8'd63,  32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0};
        vt[13] = '{1'b0, 8'd63,  32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 1'b0};
        vt[14] = '{1'b0, 8'd255, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        for (int i = 0; i < 15; i++) begin
            txn(vt[i].w, vt[i].a, vt[i].d, vt[i].b, 4'd0, lat, e, r);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
            if (vt[i].chk_rd) check($sformatf("vec%0d_rd", i), r, vt[i].exp_rd);
            if (vt[i].w) mwrite(vt[i].a, vt[i].d, vt[i].b);
            else last_rd = vt[i].exp_rd;
        end

`ifdef SIF_RESP_WAIT_EN
        model_txn("wait3", 1'b0, 8'd3, 32'h0, 4'h0, 4'd3);
        model_txn("wait0", 1'b0, 8'd63, 32'h0, 4'h0, 4'd0);
        model_txn("wait15", 1'b1, 8'd7, 32'h5A5A5A5A, 4'hF, 4'd15);
`endif
        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom);
            a  = ($urandom % 8 == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
            b  = 4'($urandom);
            wc = 4'($urandom);
            model_txn("rand", w, a, $urandom, b, wc);
        end

        // Back-to-back: req held through ack starts the next transaction two cycles later.
        we = 1'b0; addr = 8'd3; be = 4'h0; wait_cfg = 4'd0; req = 1'b1; t = 0;
        do begin @(posedge clk); #1; t++; end while (!ack && t < 40);
        check("b2b_first_rd", rd, mm[3]);
        addr = 8'd63; t = 0;
        do begin @(posedge clk); #1; t++; end while (!ack && t < 40);
        check("b2b_gap", 32'(t), 32'd2);
        check("b2b_second_rd", rd, mm[63]);
        req = 1'b0;
        @(posedge clk); #1;
        check("b2b_ack_drop", 32'(ack), 32'd0);
        last_rd = mm[63];

        // Reset while a write to addr 5 is in flight: nothing may commit.
`ifdef SIF_RESP_WAIT_EN
        we = 1'b1; addr = 8'd5; wd = 32'h12345678; be = 4'hF; wait_cfg = 4'd6; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1 check("rst_async_busy", 32'(busy), 32'd0);
        #2 rst = 1'b0;
`else
        we = 1'b1; addr = 8'd5; wd = 32'h12345678; be = 4'hF; wait_cfg = 4'd0; req = 1'b1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        req = 1'b0; rst = 1'b0;
`endif
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("post_rst_ack", 32'(ack), 32'd0);
        end
        check("post_rst_rd", rd, 32'd0);
        last_rd = 32'd0;
        model_txn("post_rst_read5", 1'b0, 8'd5, 32'h0, 4'h0, 4'd0);
        model_txn("post_rst_read3", 1'b0, 8'd3, 32'h0, 4'h0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
